// File: rtl/array_stream_fill.sv
// -----------------------------------------------------------------------------
// array_stream_fill
//
// Stream-to-array writer. Accepts a valid/ready stream of W-bit elements and
// scatters them into a 3-D array [D0][D1][D2] in foreach order (i outer,
// j middle, k inner). The array is presented as one flat vector. A running
// element count and a 32-bit running sum of written data are kept alongside.
//
// Ports
//   clk       in   1            clock, rising edge
//   rst       in   1            asynchronous, active-high reset
//   start     in   1            one-cycle pulse, begins a fill (honoured in IDLE)
//   in_valid  in   1            element beat valid
//   in_ready  out  1            high while filling
//   in_data   in   W            element value
//   in_last   in   1            terminate the fill after this beat
//   busy      out  1            fill in progress or completing
//   done      out  1            one-cycle pulse, fill complete
//   arr_flat  out  N*W          element (i,j,k) at LSB offset ((i*D1+j)*D2+k)*W
//   count     out  CW           elements written this fill
//   sum       out  32           running sum of in_data, wraps mod 2^32
// -----------------------------------------------------------------------------
module array_stream_fill #(
    parameter int W              = 8,
    parameter int D0             = 2,
    parameter int D1             = 4,
    parameter int D2             = 3,
    parameter bit DIM1_DESC      = 1'b1,
    parameter bit CLEAR_ON_START = 1'b0,
    localparam int N             = D0 * D1 * D2,
    localparam int CW            = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            busy,
    output logic            done,
    output logic [N*W-1:0]  arr_flat,
    output logic [CW-1:0]   count,
    output logic [31:0]     sum
);

    localparam int IW = (D0 > 1) ? $clog2(D0) : 1;
    localparam int JW = (D1 > 1) ? $clog2(D1) : 1;
    localparam int KW = (D2 > 1) ? $clog2(D2) : 1;
    localparam int AW = (N * W > 1) ? $clog2(N * W) : 1;

    // j runs from J_START to J_END; direction follows the declared range.
    localparam logic [JW-1:0] J_START = DIM1_DESC ? JW'(D1 - 1) : '0;
    localparam logic [JW-1:0] J_END   = DIM1_DESC ? '0 : JW'(D1 - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(D2 - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(D0 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [N*W-1:0]   arr_q, arr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      sum_q, sum_d;

    logic             beat;
    logic             last_elem;
    int               wr_off;
    logic [AW-1:0]    wr_bit;

    assign beat      = in_valid && (state_q == FILL);
    assign last_elem = (i_q == I_LAST) && (j_q == J_END) && (k_q == K_LAST);

    // Bit position of element (i,j,k) in the flat vector.
    always_comb begin
        wr_off = (int'(i_q) * D1 + int'(j_q)) * D2 + int'(k_q);
        wr_bit = AW'(wr_off * W);
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        arr_d   = arr_q;
        count_d = count_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    i_d     = '0;
                    j_d     = J_START;
                    k_d     = '0;
                    count_d = '0;
                    sum_d   = '0;
                    if (CLEAR_ON_START) arr_d = '0;
                end
            end

            FILL: begin
                if (beat) begin
                    arr_d[wr_bit +: W] = in_data;
                    count_d = count_q + 1'b1;
                    sum_d   = sum_q + 32'(in_data);

                    // Odometer advance: k fastest, then j, then i. The wrap of
                    // i after the final element is harmless: the FSM leaves
                    // FILL and the next start reloads every index.
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (j_q == J_END) begin
                            j_d = J_START;
                            i_d = i_q + 1'b1;
                        end else begin
                            j_d = DIM1_DESC ? j_q - 1'b1 : j_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end

                    if (last_elem || in_last) state_d = DONE;
                end
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            // NOTE: the array storage is reset explicitly because arr_flat is
            // an observable output that must read zero after reset; plain
            // data memories elsewhere would normally be left unreset.
            arr_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            arr_q   <= arr_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign arr_flat = arr_q;
    assign count    = count_q;
    assign sum      = sum_q;

endmodule
